// File: rtl/dev_arbiter.sv
// Two-master arbiter sharing one RAM/VGA device bus with round-robin grant and strobe/ack handshake.
// Optional abort timer compiled in with `define ARB_TIMEOUT_EN (default build waits for ack indefinitely).
//
// state    | meaning
// IDLE     | no owner; pick an eligible requester, latch its command
// ISSUE    | wait for target ack low, then raise the single strobe
// WAIT_ACK | strobe held until target ack (or timeout abort)
// RESP     | owner's done pulse, err/rdata valid alongside
module dev_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RD_BIT         = 0,
    parameter int unsigned WR_BIT         = 1,
    parameter int unsigned ACK_BIT        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_dev,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_dev,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    input  logic [31:0] ram_stat,
    output logic [31:0] ram_ctrl,
    input  logic [31:0] vga_stat,
    output logic [31:0] vga_ctrl,
    output logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

    localparam logic [31:0] RD_MASK = 32'd1 << RD_BIT;
    localparam logic [31:0] WR_MASK = 32'd1 << WR_BIT;

    state_t      state;
    logic        lat_we;
    logic        lat_dev;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        rr_m1_next;
    logic        m0_done_q;
    logic        m1_done_q;

    logic        m0_elig;
    logic        m1_elig;
    logic        grant_m1;
    logic        sel_we;
    logic        sel_dev;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        tgt_ack;
    logic        tmo_hit;
    logic        finish;
    logic        fin_err;
    logic        fin_capture;
    logic        unused_bits;

    assign unused_bits = ^{ram_stat, vga_stat, TIMEOUT_CYCLES};

    always_comb begin
        // a master that just saw done sits out one IDLE cycle so it can drop req
        m0_elig     = m0_req & ~m0_done_q;
        m1_elig     = m1_req & ~m1_done_q;
        grant_m1    = m1_elig & (~m0_elig | rr_m1_next);
        sel_we      = grant_m1 ? m1_we    : m0_we;
        sel_dev     = grant_m1 ? m1_dev   : m0_dev;
        sel_addr    = grant_m1 ? m1_addr  : m0_addr;
        sel_wdata   = grant_m1 ? m1_wdata : m0_wdata;
        tgt_ack     = lat_dev ? vga_stat[ACK_BIT] : ram_stat[ACK_BIT];
        finish      = ((state == ISSUE) && tmo_hit) ||
                      ((state == WAIT_ACK) && (tgt_ack || tmo_hit));
        fin_err     = !((state == WAIT_ACK) && tgt_ack);
        fin_capture = (state == WAIT_ACK) && tgt_ack && !lat_dev && !lat_we;
    end

`ifdef ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = ((state == ISSUE) || (state == WAIT_ACK)) &&
                     (tmo_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == ISSUE) || (state == WAIT_ACK)) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_dev    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rr_m1_next <= 1'b0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_done    <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_done    <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
            ram_ctrl   <= '0;
            vga_ctrl   <= '0;
            addr       <= '0;
            data_out   <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            m0_done_q <= m0_done;
            m1_done_q <= m1_done;
            case (state)
                IDLE: begin
                    if (m0_elig || m1_elig) begin
                        owner      <= grant_m1;
                        rr_m1_next <= ~grant_m1;
                        lat_we     <= sel_we;
                        lat_dev    <= sel_dev;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        busy       <= 1'b1;
                        // VGA has no read path: answer immediately with an error
                        if (sel_dev && !sel_we) begin
                            state <= RESP;
                            if (grant_m1) begin
                                m1_done <= 1'b1;
                                m1_err  <= 1'b1;
                            end else begin
                                m0_done <= 1'b1;
                                m0_err  <= 1'b1;
                            end
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE, WAIT_ACK: begin
                    if (finish) begin
                        ram_ctrl <= '0;
                        vga_ctrl <= '0;
                        addr     <= '0;
                        data_out <= '0;
                        state    <= RESP;
                        if (owner) begin
                            m1_done <= 1'b1;
                            m1_err  <= fin_err;
                            if (fin_capture) m1_rdata <= data_in;
                        end else begin
                            m0_done <= 1'b1;
                            m0_err  <= fin_err;
                            if (fin_capture) m0_rdata <= data_in;
                        end
                    end else if ((state == ISSUE) && !tgt_ack) begin
                        if (lat_dev) vga_ctrl <= WR_MASK;
                        else         ram_ctrl <= lat_we ? WR_MASK : RD_MASK;
                        addr     <= lat_addr;
                        data_out <= lat_we ? lat_wdata : '0;
                        state    <= WAIT_ACK;
                    end
                end
                RESP: begin
                    m0_done <= 1'b0;
                    m1_done <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_arbiter.sv
// Directed-vector bench for dev_arbiter; device acks come from a manual value or echo the strobe.
// Builds with or without ARB_TIMEOUT_EN (TIMEOUT_CYCLES overridden to 8).
module tb_dev_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_dev;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_done, m0_err;
    logic        m1_req, m1_we, m1_dev;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_done, m1_err;
    logic [31:0] ram_stat, ram_ctrl, vga_stat, vga_ctrl;
    logic [31:0] addr, data_in, data_out;
    logic        busy, owner;

    logic        ram_auto, vga_auto;
    logic [31:0] ram_man, vga_man;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ram_stat = ram_auto ? {31'b0, |ram_ctrl} : ram_man;
    assign vga_stat = vga_auto ? {31'b0, |vga_ctrl} : vga_man;

    dev_arbiter #(.TIMEOUT_CYCLES(8), .RD_BIT(0), .WR_BIT(1), .ACK_BIT(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_dev(m0_dev), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_dev(m1_dev), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_stat(ram_stat), .ram_ctrl(ram_ctrl), .vga_stat(vga_stat), .vga_ctrl(vga_ctrl),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .busy(busy), .owner(owner)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = m0_done | m1_done;
        end
        chk_val("done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_dev = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_dev = 0; m1_addr = '0; m1_wdata = '0;
        data_in = '0; ram_auto = 0; vga_auto = 0; ram_man = '0; vga_man = '0;
        tick(); tick();
        chk_val("rst_busy", {31'b0, busy}, 32'd0);
        chk_val("rst_owner", {31'b0, owner}, 32'd0);
        chk_val("rst_ctrl", ram_ctrl | vga_ctrl, 32'd0);
        chk_val("rst_bus", addr | data_out, 32'd0);
        chk_val("rst_done", {28'b0, m1_done, m1_err, m0_done, m0_err}, 32'd0);
        rst = 1'b0;
        tick();

        // m0 RAM write, ack one cycle after strobe
        m0_we = 1; m0_dev = 0; m0_addr = 32'h10; m0_wdata = 32'hCAFE; m0_req = 1;
        tick();
        chk_val("wr_busy", {31'b0, busy}, 32'd1);
        chk_val("wr_owner", {31'b0, owner}, 32'd0);
        chk_val("wr_issue_ctrl", ram_ctrl, 32'd0);
        tick();
        chk_val("wr_strobe", ram_ctrl, 32'h2);
        chk_val("wr_addr", addr, 32'h10);
        chk_val("wr_data", data_out, 32'hCAFE);
        ram_man = 32'h1;
        tick();
        chk_val("wr_strobe_off", ram_ctrl, 32'd0);
        chk_val("wr_done", {30'b0, m0_done, m0_err}, 32'h2);
        m0_req = 0; ram_man = '0;
        tick();
        chk_val("wr_done_off", {31'b0, m0_done}, 32'd0);
        chk_val("wr_idle", {31'b0, busy}, 32'd0);

        // m1 RAM read
        m1_we = 0; m1_dev = 0; m1_addr = 32'h20; data_in = 32'h1234; m1_req = 1;
        tick();
        chk_val("rd_owner", {31'b0, owner}, 32'd1);
        tick();
        chk_val("rd_strobe", ram_ctrl, 32'h1);
        chk_val("rd_addr", addr, 32'h20);
        chk_val("rd_data_out", data_out, 32'd0);
        ram_man = 32'h1;
        tick();
        chk_val("rd_done", {30'b0, m1_done, m1_err}, 32'h2);
        chk_val("rd_rdata", m1_rdata, 32'h1234);
        chk_val("rd_m0_quiet", {30'b0, m0_done, m0_err}, 32'd0);
        chk_val("rd_m0_rdata", m0_rdata, 32'd0);
        m1_req = 0; ram_man = '0;
        tick();
        chk_val("rd_done_off", {31'b0, m1_done}, 32'd0);

        // both masters requesting continuously
        ram_auto = 1;
        m0_we = 1; m0_addr = 32'hA0; m0_wdata = 32'h1;
        m1_we = 1; m1_addr = 32'hB0; m1_wdata = 32'h2;
        m0_req = 1; m1_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_done(20);
            chk_val("rr_owner", {31'b0, owner}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk_val("rr_done_pair", {30'b0, m1_done, m0_done}, (k % 2 == 1) ? 32'd2 : 32'd1);
        end
        m0_req = 0; m1_req = 0;
        tick(); tick();

        // simultaneous ties with no holdoff in play
        m0_req = 1; m1_req = 1;
        tick();
        chk_val("tie_after_m1", {31'b0, owner}, 32'd0);
        wait_done(20);
        m0_req = 0; m1_req = 0;
        tick(); tick();
        m0_req = 1; m1_req = 1;
        tick();
        chk_val("tie_after_m0", {31'b0, owner}, 32'd1);
        wait_done(20);
        chk_val("tie_m1_done", {31'b0, m1_done}, 32'd1);
        m0_req = 0; m1_req = 0;
        tick(); tick();

        // m0 VGA read is refused
        ram_auto = 0;
        m0_we = 0; m0_dev = 1; m0_addr = 32'h200; m0_req = 1;
        tick();
        chk_val("vrd_done_err", {30'b0, m0_done, m0_err}, 32'h3);
        chk_val("vrd_ctrl", ram_ctrl | vga_ctrl, 32'd0);
        m0_req = 0;
        tick();
        chk_val("vrd_done_off", {31'b0, m0_done}, 32'd0);
        chk_val("vrd_idle", {31'b0, busy}, 32'd0);

        // m0 VGA write: holdoff cycle, wait while ack high, ignore input changes after grant
        vga_man = 32'h1;
        m0_we = 1; m0_dev = 1; m0_addr = 32'h300; m0_wdata = 32'h55; m0_req = 1;
        tick();
        chk_val("holdoff_idle", {31'b0, busy}, 32'd0);
        tick();
        chk_val("vwr_grant", {30'b0, busy, owner}, 32'h2);
        tick();
        chk_val("vwr_wait_ack", vga_ctrl, 32'd0);
        m0_addr = 32'h999; m1_addr = 32'h777; m1_wdata = 32'h66; vga_man = '0;
        tick();
        chk_val("vwr_strobe", vga_ctrl, 32'h2);
        chk_val("vwr_ram_quiet", ram_ctrl, 32'd0);
        chk_val("vwr_addr", addr, 32'h300);
        chk_val("vwr_data", data_out, 32'h55);
        vga_man = 32'h1;
        tick();
        chk_val("vwr_done", {30'b0, m0_done, m0_err}, 32'h2);
        chk_val("vwr_strobe_off", vga_ctrl, 32'd0);
        m0_req = 0; vga_man = '0;
        tick(); tick();

        // RAM read whose ack never comes
        m0_we = 0; m0_dev = 0; m0_addr = 32'h40; data_in = 32'hDEAD; ram_man = '0; m0_req = 1;
`ifdef ARB_TIMEOUT_EN
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_val("tmo_strobe_held", ram_ctrl, 32'h1);
        end
        tick();
        chk_val("tmo_strobe_off", ram_ctrl, 32'd0);
        chk_val("tmo_done_err", {30'b0, m0_done, m0_err}, 32'h3);
        chk_val("tmo_rdata", m0_rdata, 32'd0);
        m0_req = 0;
        tick(); tick();
        m0_req = 1;
        tick(); tick();
`else
        for (int i = 0; i < 12; i++) tick();
        chk_val("hang_busy", {31'b0, busy}, 32'd1);
        chk_val("hang_strobe", ram_ctrl, 32'h1);
        chk_val("hang_no_done", {31'b0, m0_done}, 32'd0);
`endif

        // reset mid WAIT_ACK
        m0_req = 0;
        rst = 1'b1;
        #1;
        chk_val("arst_strobe", ram_ctrl, 32'd0);
        chk_val("arst_busy", {31'b0, busy}, 32'd0);
        tick(); tick();
        chk_val("arst_no_done", {31'b0, m0_done}, 32'd0);
        rst = 1'b0;
        tick();
        ram_auto = 1;
        m0_we = 1; m0_dev = 0; m0_addr = 32'h50; m0_wdata = 32'hAA;
        m1_we = 1; m1_dev = 0; m1_addr = 32'h60; m1_wdata = 32'hBB;
        m0_req = 1; m1_req = 1;
        tick();
        chk_val("post_rst_tie", {31'b0, owner}, 32'd0);
        tick();
        chk_val("post_rst_addr", addr, 32'h50);
        chk_val("post_rst_strobe", ram_ctrl, 32'h2);
        tick();
        chk_val("post_rst_done", {30'b0, m0_done, m0_err}, 32'h2);
        m0_req = 0; m1_req = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
